// File: rtl/front_panel_scan_pkg.sv
// Shared types and constants for the front-panel LED matrix scanner.
package front_panel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  localparam int NUM_ROWS = 5;
  localparam int NUM_COLS = 8;

  localparam logic [2:0] ROW_ADDR_LO = 3'd0;
  localparam logic [2:0] ROW_ADDR_HI = 3'd1;
  localparam logic [2:0] ROW_DATA    = 3'd2;
  localparam logic [2:0] ROW_STATUS  = 3'd3;
  localparam logic [2:0] ROW_CTRL    = 3'd4;

  // Column level that leaves every LED in a column dark.
  function automatic logic [NUM_COLS-1:0] col_off(input bit active_low);
    return active_low ? {NUM_COLS{1'b1}} : {NUM_COLS{1'b0}};
  endfunction

endpackage

// File: rtl/front_panel_scan_if.sv
// Monitor-byte inputs and LED-matrix outputs of the front-panel scanner.
interface front_panel_scan_if;

  logic [15:0]                         mon_addr;
  logic [7:0]                          mon_data;
  logic [7:0]                          mon_status;
  logic [7:0]                          mon_ctrl;
  logic [3:0]                          brightness;
  logic [front_panel_pkg::NUM_ROWS-1:0] led_row;
  logic [front_panel_pkg::NUM_COLS-1:0] led_col;
  logic                                frame_start;

  modport master (
    output mon_addr, mon_data, mon_status, mon_ctrl, brightness,
    input  led_row, led_col, frame_start
  );

  modport slave (
    input  mon_addr, mon_data, mon_status, mon_ctrl, brightness,
    output led_row, led_col, frame_start
  );

endinterface

// File: rtl/front_panel_scan.sv
// Row-multiplexed LED matrix driver: per-frame snapshot, blanking gap between
// rows and per-frame PWM brightness; all outputs come straight from flops.
module front_panel_scan
  import front_panel_pkg::*;
#(
  parameter int ROW_TICKS      = 4096,
  parameter int BLANK_TICKS    = 64,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  front_panel_scan_if.slave  bus
);

  localparam int MAXT = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
  localparam int CW   = $clog2(MAXT) + 1;

  localparam logic [CW-1:0]       ROW_LAST   = CW'(ROW_TICKS - 1);
  localparam logic [CW-1:0]       BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0]       TICK_STEP  = CW'(ROW_TICKS / 16);
  localparam logic [NUM_COLS-1:0] COL_OFF    = col_off(COL_ACTIVE_LOW);

  state_e                state_q;
  logic [2:0]            row_q;
  logic [CW-1:0]         cnt_q;
  logic [39:0]           snap_q;
  logic [3:0]            duty_q;
  logic [NUM_ROWS-1:0]   led_row_q;
  logic [NUM_COLS-1:0]   led_col_q;
  logic                  frame_start_q;

  logic [39:0]           snap_d;
  logic [CW-1:0]         cnt_inc_d;
  logic [CW-1:0]         duty_ticks_d;
  logic [NUM_ROWS-1:0]   row_onehot_d;
  logic [NUM_COLS-1:0]   row_col_d;

  // (duty+1) sixteenths of the row window; duty=15 yields exactly ROW_TICKS.
  function automatic logic [CW-1:0] duty_ticks(input logic [3:0] d);
    return (CW'(d) + CW'(1)) * TICK_STEP;
  endfunction

  function automatic logic [7:0] sel_byte(input logic [39:0] s, input logic [2:0] r);
    case (r)
      ROW_ADDR_LO: return s[7:0];
      ROW_ADDR_HI: return s[15:8];
      ROW_DATA:    return s[23:16];
      ROW_STATUS:  return s[31:24];
      ROW_CTRL:    return s[39:32];
      default:     return 8'h00;
    endcase
  endfunction

  function automatic logic [NUM_COLS-1:0] drive_col(input logic [7:0] b);
    return COL_ACTIVE_LOW ? ~b : b;
  endfunction

  always_comb begin
    snap_d       = {bus.mon_ctrl, bus.mon_status, bus.mon_data, bus.mon_addr};
    cnt_inc_d    = cnt_q + CW'(1);
    duty_ticks_d = duty_ticks(duty_q);
    row_onehot_d = NUM_ROWS'(1) << row_q;
    row_col_d    = drive_col(sel_byte(snap_q, row_q));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      row_q         <= ROW_ADDR_LO;
      cnt_q         <= '0;
      snap_q        <= '0;
      duty_q        <= '0;
      led_row_q     <= '0;
      led_col_q     <= COL_OFF;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q       <= BLANK;
          row_q         <= ROW_ADDR_LO;
          cnt_q         <= '0;
          snap_q        <= snap_d;
          duty_q        <= bus.brightness;
          frame_start_q <= 1'b1;
          led_row_q     <= '0;
          led_col_q     <= COL_OFF;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            // Duty is never below one tick, so the row always lights on entry.
            state_q   <= DRIVE;
            cnt_q     <= '0;
            led_row_q <= row_onehot_d;
            led_col_q <= row_col_d;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        DRIVE: begin
          if (cnt_q == ROW_LAST) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            led_row_q <= '0;
            led_col_q <= COL_OFF;
            if (row_q == ROW_CTRL) begin
              row_q         <= ROW_ADDR_LO;
              snap_q        <= snap_d;
              duty_q        <= bus.brightness;
              frame_start_q <= 1'b1;
            end else begin
              row_q <= row_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_inc_d;
            if (cnt_inc_d < duty_ticks_d) begin
              led_row_q <= row_onehot_d;
              led_col_q <= row_col_d;
            end else begin
              led_row_q <= '0;
              led_col_q <= COL_OFF;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          led_row_q <= '0;
          led_col_q <= COL_OFF;
        end
      endcase
    end
  end

  assign bus.led_row     = led_row_q;
  assign bus.led_col     = led_col_q;
  assign bus.frame_start = frame_start_q;

endmodule
